// File: rtl/seq_shift_add_multiplier.sv
// Sequential shift-and-add multiplier: WIDTH x WIDTH -> 2*WIDTH over WIDTH cycles with start/busy/done handshake.
// Define MULT_SIGNED_EN for two's-complement operands and product (unsigned core plus sign fix-up).
module seq_shift_add_multiplier #(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] p
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]         state_q, state_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]   mplr_q, mplr_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] p_q, p_d;

  logic               accept;
  logic [WIDTH:0]     sum;
  logic [2*WIDTH-1:0] shifted;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [2*WIDTH-1:0] result;

  // One adder step, then {carry, acc, mplr} >> 1; once the last bit is consumed this is the product.
  assign sum     = {1'b0, acc_q} + (mplr_q[0] ? {1'b0, mcand_q} : '0);
  assign shifted = {sum, mplr_q[WIDTH-1:1]};

`ifdef MULT_SIGNED_EN
  logic sign_q, sign_d;

  // |-2^(WIDTH-1)| wraps to 2^(WIDTH-1), which is exactly right when read as unsigned.
  assign a_mag  = a[WIDTH-1] ? ('0 - a) : a;
  assign b_mag  = b[WIDTH-1] ? ('0 - b) : b;
  assign sign_d = accept ? (a[WIDTH-1] ^ b[WIDTH-1]) : sign_q;
  assign result = sign_q ? ('0 - shifted) : shifted;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sign_q <= 1'b0;
    else     sign_q <= sign_d;
  end
`else
  assign a_mag  = a;
  assign b_mag  = b;
  assign result = shifted;
`endif

  assign accept = start && (state_q != S_RUN);

  always_comb begin
    // NOTE: every next-state signal takes its hold value first so no path leaves it unassigned (no latches).
    state_d = state_q;
    mcand_d = mcand_q;
    acc_d   = acc_q;
    mplr_d  = mplr_q;
    cnt_d   = cnt_q;
    p_d     = p_q;

    case (state_q)
      S_RUN: begin
        acc_d  = shifted[2*WIDTH-1:WIDTH];
        mplr_d = shifted[WIDTH-1:0];
        cnt_d  = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = S_DONE;
          p_d     = result;
        end
      end
      default: begin
        if (accept) begin
          state_d = S_RUN;
          mcand_d = a_mag;
          mplr_d  = b_mag;
          acc_d   = '0;
          cnt_d   = CW'(WIDTH);
        end else begin
          state_d = S_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      mcand_q <= '0;
      acc_q   <= '0;
      mplr_q  <= '0;
      cnt_q   <= '0;
      p_q     <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the pre-edge values together.
      state_q <= state_d;
      mcand_q <= mcand_d;
      acc_q   <= acc_d;
      mplr_q  <= mplr_d;
      cnt_q   <= cnt_d;
      p_q     <= p_d;
    end
  end

  assign busy = (state_q == S_RUN);
  assign done = (state_q == S_DONE);
  assign p    = p_q;

endmodule

// File: tb/tb_seq_shift_add_multiplier.sv
// Self-checking bench for seq_shift_add_multiplier: WIDTH=4 directed tests and a WIDTH=8 random regression,
// both compared every cycle against a countdown/arithmetic reference model.
module tb_seq_shift_add_multiplier;

  logic       clk;
  logic       rst;
  logic       start4, busy4, done4;
  logic [3:0] a4, b4;
  logic [7:0] p4;
  logic       start8, busy8, done8;
  logic [7:0] a8, b8;
  logic [15:0] p8;

  int n_checks = 0;
  int n_pass   = 0;

  seq_shift_add_multiplier #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4),
    .busy(busy4), .done(done4), .p(p4)
  );

  seq_shift_add_multiplier #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .p(p8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [7:0] prod4(input logic [3:0] x, input logic [3:0] y);
    logic [7:0] xe, ye;
`ifdef MULT_SIGNED_EN
    xe = {{4{x[3]}}, x};
    ye = {{4{y[3]}}, y};
`else
    xe = {4'b0, x};
    ye = {4'b0, y};
`endif
    return xe * ye;
  endfunction

  function automatic logic [15:0] prod8(input logic [7:0] x, input logic [7:0] y);
    logic [15:0] xe, ye;
`ifdef MULT_SIGNED_EN
    xe = {{8{x[7]}}, x};
    ye = {{8{y[7]}}, y};
`else
    xe = {8'b0, x};
    ye = {8'b0, y};
`endif
    return xe * ye;
  endfunction

  // Reference model: cycles left until completion, pending product, and visible outputs.
  int          m4_cnt, m8_cnt;
  logic        m4_done, m8_done;
  logic [7:0]  m4_pend, m4_p;
  logic [15:0] m8_pend, m8_p;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m4_cnt <= 0; m4_done <= 1'b0; m4_p <= '0; m4_pend <= '0;
    end else if (m4_cnt > 0) begin
      m4_cnt  <= m4_cnt - 1;
      m4_done <= (m4_cnt == 1);
      if (m4_cnt == 1) m4_p <= m4_pend;
    end else begin
      m4_done <= 1'b0;
      if (start4) begin
        m4_cnt  <= 4;
        m4_pend <= prod4(a4, b4);
      end
    end
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m8_cnt <= 0; m8_done <= 1'b0; m8_p <= '0; m8_pend <= '0;
    end else if (m8_cnt > 0) begin
      m8_cnt  <= m8_cnt - 1;
      m8_done <= (m8_cnt == 1);
      if (m8_cnt == 1) m8_p <= m8_pend;
    end else begin
      m8_done <= 1'b0;
      if (start8) begin
        m8_cnt  <= 8;
        m8_pend <= prod8(a8, b8);
      end
    end
  end

  always @(negedge clk) begin
    check("model_busy4", busy4, m4_cnt > 0);
    check("model_done4", done4, m4_done);
    check("model_p4",    p4,    m4_p);
    check("model_busy8", busy8, m8_cnt > 0);
    check("model_done8", done8, m8_done);
    check("model_p8",    p8,    m8_p);
  end

  // Issue one WIDTH=4 operation from a negedge and check 4-cycle latency and the literal product.
  task automatic run4(input logic [3:0] x, input logic [3:0] y, input logic [7:0] exp_p, input string name);
    int n;
    a4 = x; b4 = y; start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    n = 0;
    while (!done4 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({name, "_latency"}, n, 4);
    check({name, "_p"}, p4, exp_p);
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int lat, last, dones;
    logic [7:0] ra, rb;
    rst = 1'b1;
    start4 = 1'b0; a4 = '0; b4 = '0;
    start8 = 1'b0; a8 = '0; b8 = '0;
    repeat (2) @(negedge clk);
    check("reset_busy", busy4, 1'b0);
    check("reset_done", done4, 1'b0);
    check("reset_p",    p4,    8'h00);
    rst = 1'b0;
    @(negedge clk);

`ifdef MULT_SIGNED_EN
    run4(4'h8, 4'h8, 8'h40, "m8xm8");
    repeat (3) @(negedge clk);
    check("hold_p", p4, 8'h40);
    run4(4'hD, 4'h5, 8'hF1, "m3x5");
    run4(4'h7, 4'hF, 8'hF9, "7xm1");
    run4(4'h0, 4'hD, 8'h00, "0xm3");
`else
    run4(4'd15, 4'd15, 8'hE1, "15x15");
    repeat (3) @(negedge clk);
    check("hold_p", p4, 8'hE1);
    run4(4'd9, 4'd6, 8'h36, "9x6");
    run4(4'd0, 4'd13, 8'h00, "0x13");
`endif

    // start held high: a=7 is presented only while busy and must never be captured.
    a4 = 4'd3; b4 = 4'd5; start4 = 1'b1;
    last = -1; dones = 0;
    for (int c = 0; c < 40 && dones < 3; c++) begin
      @(negedge clk);
      if (done4) begin
        check("b2b_p", p4, 8'd15);
        if (last >= 0) check("b2b_period", c - last, 5);
        last = c;
        dones++;
      end
      a4 = busy4 ? 4'd7 : 4'd3;
    end
    check("b2b_count", dones, 3);
    start4 = 1'b0;
    repeat (2) @(negedge clk);

    // Asynchronous reset in the second RUN cycle of 12x11.
    a4 = 4'd12; b4 = 4'd11; start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("async_rst_busy", busy4, 1'b0);
    check("async_rst_done", done4, 1'b0);
    check("async_rst_p",    p4,    8'h00);
    @(negedge clk);
    a4 = 4'd2; b4 = 4'd3; start4 = 1'b1;
    #2 rst = 1'b0;
    @(posedge clk);
    #1;
    start4 = 1'b0;
    check("rst_release_accept", busy4, 1'b1);
    lat = 1;
    while (!done4 && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("rst_release_latency", lat, 5);
    check("rst_release_p", p4, 8'd6);
    @(negedge clk);

    // WIDTH=8 regression: back-to-back operations, corners first.
    for (int i = 0; i < 1000; i++) begin
      if (i == 0)      begin ra = 8'hFF; rb = 8'hFF; end
      else if (i == 1) begin ra = 8'h80; rb = 8'h80; end
      else if (i == 2) begin ra = 8'h00; rb = 8'hA5; end
      else begin
        ra = 8'($urandom_range(0, 255));
        rb = 8'($urandom_range(0, 255));
      end
      a8 = ra; b8 = rb; start8 = 1'b1;
      @(negedge clk);
      start8 = 1'b0;
      a8 = ~ra; b8 = ~rb;
      lat = 0;
      while (!done8 && lat < 30) begin
        @(negedge clk);
        lat++;
      end
      check("w8_latency", lat, 8);
      check("w8_p", p8, prod8(ra, rb));
    end
`ifndef MULT_SIGNED_EN
    check("w8_first_literal", prod8(8'hFF, 8'hFF), 16'hFE01);
`endif
    repeat (3) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/seq_shift_add_multiplier.md
Name: seq_shift_add_multiplier

Overview:
- Parametrised unsigned sequential multiplier. Successor to the fixed 2-bit full-adder array multiplier.
- Computes a WIDTH x WIDTH -> 2*WIDTH product by shift-and-add over WIDTH clock cycles, using a single WIDTH+1-bit adder.
- Start/busy/done handshake so a controller or datapath FSM can issue operands and collect the result.
- Optional signed (two's complement) mode.

Parameters:
- WIDTH, 4, operand width in bits; legal range 2..32. Product width is 2*WIDTH.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- start  input  1  request a multiply; sampled on the rising edge of clk
- a  input  WIDTH  multiplicand; captured when start is accepted
- b  input  WIDTH  multiplier; captured when start is accepted
- busy  output  1  high while an operation is in progress
- done  output  1  one-cycle pulse: p now holds a new product
- p  output  2*WIDTH  product register; holds its value until the next completion

Behaviour:
- Reset is asynchronous and active-high. rst=1 immediately forces:
  - state=IDLE, busy=0, done=0, p=0;
  - internal accumulator, operand registers and counter cleared.
- States:
  - IDLE: busy=0, done=0. If start=1, go to RUN.
  - RUN: busy=1, done=0. Perform one iteration per edge for exactly WIDTH edges, then go to DONE.
  - DONE: busy=0, done=1 for exactly one cycle. If start=1, go to RUN (back-to-back accepted); otherwise go to IDLE.
- Acceptance:
  - start is accepted only in IDLE or DONE.
  - On acceptance, register a and b, clear the accumulator, and load the counter with WIDTH.
  - start during RUN is ignored. Operands are not re-captured and no error is flagged.
- Iteration (RUN, each edge):
  - If the multiplier register LSB is 1, add the multiplicand to the upper WIDTH bits of the accumulator in a WIDTH+1-bit adder. The carry-out is preserved.
  - Then shift {carry, accumulator, multiplier} right by one.
  - Decrement the counter. On the edge where the counter reaches 0, transition to DONE.
- Latency:
  - start sampled at edge k; busy=1 after edges k..k+W-1.
  - After edge k+WIDTH: busy=0, done=1, p valid.
  - Throughput: one product per WIDTH+1 cycles with back-to-back starts.
- p register:
  - Written only on the completion edge.
  - Stable in IDLE, RUN and DONE otherwise, so the previous result stays readable during the next operation.
- Arithmetic: exact, no truncation. The maximum result (2^WIDTH-1)^2 fits in 2*WIDTH bits.
- Boundary conditions:
  - Operand 0 still takes the full WIDTH cycles (no early exit).
  - Reset asserted mid-RUN aborts the operation, clears p, and returns to IDLE. No done pulse is produced.
  - Reset released with start=1: the first edge after deassertion accepts the start.
  - a and b may change freely after acceptance.

Optional Feature:
- Macro: MULT_SIGNED_EN.
- Defined: a, b and p are two's complement.
  - On acceptance, register sign = a[MSB] XOR b[MSB] and the magnitudes |a|, |b|. |-2^(WIDTH-1)| = 2^(WIDTH-1) fits unsigned in WIDTH bits.
  - Run the unsigned core unchanged.
  - On the completion edge, write p = sign ? -mag : mag.
  - Latency and handshake are identical to unsigned mode.
- Undefined: purely unsigned; no sign logic is synthesised.

Test Plan:
- WIDTH=4, reset, then a=15, b=15, start pulse -> busy high 4 cycles, then done=1 for 1 cycle with p=8'hE1 (225); p unchanged afterwards.
- a=9, b=6 -> p=8'h36 (54) after 4 cycles; then a=0, b=13 -> p=8'h00, still 4-cycle latency.
- start held high continuously with a=3, b=5 -> done every 5 cycles, p=15 each time; start pulses during RUN with a=7 are ignored (p stays 15, never 49).
- rst asserted asynchronously (between edges) in the 2nd RUN cycle of a=12, b=11 -> busy, done and p go to 0 immediately; no done pulse follows; the next start with a=2, b=3 gives p=6.
- WIDTH=8 regression, random a and b (1000 operations) -> p equals a*b and done arrives exactly 8 cycles after each accepted start.
- MULT_SIGNED_EN, WIDTH=4: a=-8, b=-8 -> p=8'h40 (64); a=-3, b=5 -> p=8'hF1 (-15); a=7, b=-1 -> p=8'hF9 (-7).
